vga_timing_gen: RTL and testbench

- Parametrised video timing generator producing VGA-style hsync/vsync/blank and pixel coordinates in the clk_pixel domain.
- Feeds vga2dvid directly and drives framebuffer prefetch via a lookahead coordinate port.
- Successor to the fixed-function test-picture VGA generator: adds sync polarity control, clock enable, frame/line strobes and a lookahead fetch port.

---
 rtl/video_timing_pkg.sv | 33 +++
 rtl/vga_timing_gen_timing_axis.sv | 49 ++++
 rtl/vga_timing_gen.sv | 176 +++++++++++++++++
 tb/tb_vga_timing_gen.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// ---------------------------------------------------------------------------
// video_timing_pkg
// Shared helpers for the video timing generator:
//   - axis_total   : total count of one axis (visible + porches + pulse)
//   - sync_first   : first count value inside the sync pulse
//   - sync_last    : last count value inside the sync pulse
//   - sync_level   : maps a logical "sync active" flag onto the pin level
//   - POLARITY_*   : polarity encodings for the C_*sync_polarity parameters
// ---------------------------------------------------------------------------
package video_timing_pkg;

    localparam bit POLARITY_ACTIVE_LOW  = 1'b0;
    localparam bit POLARITY_ACTIVE_HIGH = 1'b1;

    function automatic int axis_total(int res, int fp, int pulse, int bp);
        return res + fp + pulse + bp;
    endfunction

    function automatic int sync_first(int res, int fp);
        return res + fp;
    endfunction

    function automatic int sync_last(int res, int fp, int pulse);
        return res + fp + pulse - 1;
    endfunction

    // Pin level for a sync signal: an active-low output (polarity 0) drives 0
    // while active and 1 while idle.
    function automatic logic sync_level(logic active, bit polarity);
        return active ^ ~polarity;
    endfunction

endpackage

// File: rtl/vga_timing_gen_timing_axis.sv
// ---------------------------------------------------------------------------
// timing_axis
// One-dimensional timing counter: counts 0..TOTAL-1 while advance is high and
// decodes the visible window and the sync window from the current count.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   advance      : count step qualifier
//   count        : current position on this axis
//   visible      : count lies inside the visible area
//   sync_active  : count lies inside the sync pulse window
//   carry        : count is the last value of the axis (wraps on next advance)
// ---------------------------------------------------------------------------
module timing_axis
    import video_timing_pkg::*;
#(
    parameter int C_res   = 1024,
    parameter int C_fp    = 16,
    parameter int C_pulse = 96,
    parameter int C_bp    = 44,
    parameter int C_bits  = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              advance,
    output logic [C_bits-1:0] count,
    output logic              visible,
    output logic              sync_active,
    output logic              carry
);

    localparam int TOTAL = axis_total(C_res, C_fp, C_pulse, C_bp);
    localparam logic [C_bits-1:0] LAST       = C_bits'(TOTAL - 1);
    localparam logic [C_bits-1:0] RES        = C_bits'(C_res);
    localparam logic [C_bits-1:0] SYNC_FIRST = C_bits'(sync_first(C_res, C_fp));
    localparam logic [C_bits-1:0] SYNC_LAST  = C_bits'(sync_last(C_res, C_fp, C_pulse));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (advance) begin
            count <= carry ? '0 : count + 1'b1;
        end
    end

    assign carry       = (count == LAST);
    assign visible     = (count < RES);
    assign sync_active = (count >= SYNC_FIRST) && (count <= SYNC_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// Parametrised VGA-style timing generator in the clk_pixel domain. All
// outputs are registered one cycle after the h/v counter state. fetch_x /
// fetch_y lead out_x / out_y by C_lookahead enabled cycles for framebuffer
// prefetch.
// Optional feature macro: VGA_TEST_PICTURE_EN
//   defined   : vga_r/g/b carry a test pattern derived from the coordinates
//   undefined : vga_r/g/b are tied to 0
// Ports:
//   clk_pixel, reset        : pixel clock, asynchronous active-high reset
//   enable                  : pixel clock enable, low freezes all state
//   out_x, out_y            : current pixel coordinates
//   fetch_x, fetch_y        : coordinates C_lookahead pixels ahead
//   fetch_valid             : fetch position lies in the visible area
//   vga_hsync, vga_vsync    : sync outputs, level set by C_*sync_polarity
//   vga_blank               : outside the visible area
//   line_start, frame_start : strobes at h==0 / h==0,v==0 (hold while !enable)
//   vga_r, vga_g, vga_b     : test colour
// ---------------------------------------------------------------------------
module vga_timing_gen
    import video_timing_pkg::*;
#(
    parameter int C_resolution_x      = 1024,
    parameter int C_hsync_front_porch = 16,
    parameter int C_hsync_pulse       = 96,
    parameter int C_hsync_back_porch  = 44,
    parameter int C_resolution_y      = 768,
    parameter int C_vsync_front_porch = 10,
    parameter int C_vsync_pulse       = 2,
    parameter int C_vsync_back_porch  = 31,
    parameter int C_bits_x            = 11,
    parameter int C_bits_y            = 11,
    parameter bit C_hsync_polarity    = POLARITY_ACTIVE_LOW,
    parameter bit C_vsync_polarity    = POLARITY_ACTIVE_LOW,
    parameter int C_lookahead         = 2,
    parameter int C_depth             = 2
) (
    input  logic                clk_pixel,
    input  logic                reset,
    input  logic                enable,
    output logic [C_bits_x-1:0] out_x,
    output logic [C_bits_y-1:0] out_y,
    output logic [C_bits_x-1:0] fetch_x,
    output logic [C_bits_y-1:0] fetch_y,
    output logic                fetch_valid,
    output logic                vga_hsync,
    output logic                vga_vsync,
    output logic                vga_blank,
    output logic                line_start,
    output logic                frame_start,
    output logic [C_depth-1:0]  vga_r,
    output logic [C_depth-1:0]  vga_g,
    output logic [C_depth-1:0]  vga_b
);

    localparam int H_TOTAL = axis_total(C_resolution_x, C_hsync_front_porch,
                                        C_hsync_pulse, C_hsync_back_porch);
    localparam int V_TOTAL = axis_total(C_resolution_y, C_vsync_front_porch,
                                        C_vsync_pulse, C_vsync_back_porch);
    localparam logic [C_bits_x-1:0] RES_X = C_bits_x'(C_resolution_x);
    localparam logic [C_bits_y-1:0] RES_Y = C_bits_y'(C_resolution_y);

    // Lookahead position seen while the counters sit at (0,0) in reset.
    localparam logic [C_bits_x-1:0] FETCH_X_RESET = C_bits_x'(C_lookahead % H_TOTAL);
    localparam logic [C_bits_y-1:0] FETCH_Y_RESET = C_bits_y'((C_lookahead / H_TOTAL) % V_TOTAL);

    logic [C_bits_x-1:0] h;
    logic [C_bits_y-1:0] v;
    logic h_visible, h_sync, h_carry;
    logic v_visible, v_sync, v_carry;
    logic v_advance;

    int                  h_ahead;
    logic [C_bits_x-1:0] fetch_x_next;
    logic [C_bits_y-1:0] fetch_y_next;
    logic                fetch_valid_next;

    assign v_advance = enable & h_carry;

    timing_axis #(
        .C_res   (C_resolution_x),
        .C_fp    (C_hsync_front_porch),
        .C_pulse (C_hsync_pulse),
        .C_bp    (C_hsync_back_porch),
        .C_bits  (C_bits_x)
    ) u_h_axis (
        .clk         (clk_pixel),
        .reset       (reset),
        .advance     (enable),
        .count       (h),
        .visible     (h_visible),
        .sync_active (h_sync),
        .carry       (h_carry)
    );

    timing_axis #(
        .C_res   (C_resolution_y),
        .C_fp    (C_vsync_front_porch),
        .C_pulse (C_vsync_pulse),
        .C_bp    (C_vsync_back_porch),
        .C_bits  (C_bits_y)
    ) u_v_axis (
        .clk         (clk_pixel),
        .reset       (reset),
        .advance     (v_advance),
        .count       (v),
        .visible     (v_visible),
        .sync_active (v_sync),
        .carry       (v_carry)
    );

    // C_lookahead is below H_total, so at most one line wrap can occur and a
    // single subtraction brings the sum back into range.
    always_comb begin
        h_ahead      = int'(h) + C_lookahead;
        fetch_x_next = C_bits_x'(h_ahead);
        fetch_y_next = v;
        if (h_ahead >= H_TOTAL) begin
            fetch_x_next = C_bits_x'(h_ahead - H_TOTAL);
            fetch_y_next = v_carry ? '0 : v + 1'b1;
        end
        fetch_valid_next = (fetch_x_next < RES_X) && (fetch_y_next < RES_Y);
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            out_x       <= '0;
            out_y       <= '0;
            fetch_x     <= FETCH_X_RESET;
            fetch_y     <= FETCH_Y_RESET;
            fetch_valid <= 1'b0;
            vga_blank   <= 1'b1;
            vga_hsync   <= sync_level(1'b0, C_hsync_polarity);
            vga_vsync   <= sync_level(1'b0, C_vsync_polarity);
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (enable) begin
            out_x       <= h;
            out_y       <= v;
            fetch_x     <= fetch_x_next;
            fetch_y     <= fetch_y_next;
            fetch_valid <= fetch_valid_next;
            vga_blank   <= ~(h_visible & v_visible);
            vga_hsync   <= sync_level(h_sync, C_hsync_polarity);
            vga_vsync   <= sync_level(v_sync, C_vsync_polarity);
            line_start  <= (h == '0);
            frame_start <= (h == '0) && (v == '0);
        end
    end

`ifdef VGA_TEST_PICTURE_EN
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            vga_r <= '0;
            vga_g <= '0;
            vga_b <= '0;
        end else if (enable) begin
            if (h_visible && v_visible) begin
                vga_r <= h[C_depth-1:0];
                vga_g <= v[C_depth-1:0];
                vga_b <= h[C_depth-1:0] ^ v[C_depth-1:0];
            end else begin
                vga_r <= '0;
                vga_g <= '0;
                vga_b <= '0;
            end
        end
    end
`else
    assign vga_r = '0;
    assign vga_g = '0;
    assign vga_b = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
// Self-checking bench for vga_timing_gen with a tiny 8x4 raster
// (H_total = 12, V_total = 7, lookahead 2, active-low syncs). Expected output
// words are derived from the timing rules, queued when a cycle is driven and
// compared after the clock edge that produces them.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

    localparam int HT = 12;
    localparam int VT = 7;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic [10:0] fx;
        logic [10:0] fy;
        logic        fv;
        logic        hs;
        logic        vs;
        logic        blank;
        logic        ls;
        logic        fs;
        logic [1:0]  r;
        logic [1:0]  g;
        logic [1:0]  b;
    } vid_t;

    logic        clk_pixel = 1'b0;
    logic        reset     = 1'b1;
    logic        enable    = 1'b0;
    logic [10:0] out_x, out_y, fetch_x, fetch_y;
    logic        fetch_valid, vga_hsync, vga_vsync, vga_blank;
    logic        line_start, frame_start;
    logic [1:0]  vga_r, vga_g, vga_b;

    int   checks = 0;
    int   errors = 0;
    int   mh = 0;
    int   mv = 0;
    vid_t held;
    vid_t sb[$];

    always #5 clk_pixel = ~clk_pixel;

    vga_timing_gen #(
        .C_resolution_x      (8),
        .C_hsync_front_porch (1),
        .C_hsync_pulse       (2),
        .C_hsync_back_porch  (1),
        .C_resolution_y      (4),
        .C_vsync_front_porch (1),
        .C_vsync_pulse       (1),
        .C_vsync_back_porch  (1),
        .C_bits_x            (11),
        .C_bits_y            (11),
        .C_hsync_polarity    (1'b0),
        .C_vsync_polarity    (1'b0),
        .C_lookahead         (2),
        .C_depth             (2)
    ) dut (
        .clk_pixel   (clk_pixel),
        .reset       (reset),
        .enable      (enable),
        .out_x       (out_x),
        .out_y       (out_y),
        .fetch_x     (fetch_x),
        .fetch_y     (fetch_y),
        .fetch_valid (fetch_valid),
        .vga_hsync   (vga_hsync),
        .vga_vsync   (vga_vsync),
        .vga_blank   (vga_blank),
        .line_start  (line_start),
        .frame_start (frame_start),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b)
    );

    function automatic vid_t reset_word();
        vid_t e;
        e       = '0;
        e.fx    = 11'd2;
        e.hs    = 1'b1;
        e.vs    = 1'b1;
        e.blank = 1'b1;
        return e;
    endfunction

    // Output word the DUT must register when its counters sit at (h,v).
    function automatic vid_t model_out(int h, int v);
        vid_t e;
        int   fx, fy;
        fx = h + 2;
        fy = v;
        if (fx >= HT) begin
            fx = fx - HT;
            fy = (v + 1) % VT;
        end
        e       = '0;
        e.x     = 11'(h);
        e.y     = 11'(v);
        e.fx    = 11'(fx);
        e.fy    = 11'(fy);
        e.fv    = (fx < 8) && (fy < 4);
        e.blank = (h >= 8) || (v >= 4);
        e.hs    = !(h == 9 || h == 10);
        e.vs    = (v != 5);
        e.ls    = (h == 0);
        e.fs    = (h == 0) && (v == 0);
`ifdef VGA_TEST_PICTURE_EN
        if (!e.blank) begin
            e.r = 2'(h);
            e.g = 2'(v);
            e.b = 2'(h) ^ 2'(v);
        end
`endif
        return e;
    endfunction

    function automatic vid_t sample();
        vid_t o;
        o.x = out_x;  o.y = out_y;  o.fx = fetch_x;  o.fy = fetch_y;
        o.fv = fetch_valid;  o.hs = vga_hsync;  o.vs = vga_vsync;
        o.blank = vga_blank;  o.ls = line_start;  o.fs = frame_start;
        o.r = vga_r;  o.g = vga_g;  o.b = vga_b;
        return o;
    endfunction

    // Drives one clock with the given enable and queues the word expected
    // after that edge; returns #1 after the edge.
    task automatic drive_cycle(input bit en);
        @(negedge clk_pixel);
        enable = en;
        if (en) begin
            held = model_out(mh, mv);
            mh++;
            if (mh == HT) begin
                mh = 0;
                mv = (mv + 1) % VT;
            end
        end
        sb.push_back(held);
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic restart_model();
        mh   = 0;
        mv   = 0;
        held = reset_word();
        sb.delete();
    endtask

    task automatic test_reset();
        vid_t obs, exp;
        reset  = 1'b1;
        enable = 1'b0;
        repeat (3) @(posedge clk_pixel);
        #1;
        obs = sample();
        exp = reset_word();
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL reset_values: got %h expected %h", obs, exp);
        end
        @(negedge clk_pixel);
        reset = 1'b0;
        restart_model();
    endtask

    task automatic test_line();
        vid_t obs, exp;
        int   hs_low = 0;
        for (int i = 0; i < 13; i++) begin
            drive_cycle(1'b1);
            exp = sb.pop_front();
            obs = sample();
            if (!obs.hs) hs_low++;
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("[TB] FAIL line_step%0d: got %h expected %h", i, obs, exp);
            end
        end
        checks++;
        if (hs_low !== 2) begin
            errors++;
            $display("[TB] FAIL hsync_low_count: got %0d expected 2", hs_low);
        end
    endtask

    task automatic test_frame();
        vid_t obs, exp;
        int   fs_count = 0;
        int   vs_low   = 0;
        for (int i = 0; i < HT * VT; i++) begin
            drive_cycle(1'b1);
            exp = sb.pop_front();
            obs = sample();
            if (obs.fs) fs_count++;
            if (!obs.vs) vs_low++;
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("[TB] FAIL frame_step%0d: got %h expected %h", i, obs, exp);
            end
        end
        checks++;
        if (fs_count !== 1) begin
            errors++;
            $display("[TB] FAIL frame_start_count: got %0d expected 1", fs_count);
        end
        checks++;
        if (vs_low !== 12) begin
            errors++;
            $display("[TB] FAIL vsync_low_count: got %0d expected 12", vs_low);
        end
    endtask

    task automatic test_lookahead();
        vid_t obs, exp;
        bit   found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            drive_cycle(1'b1);
            exp = sb.pop_front();
            obs = sample();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("[TB] FAIL lookahead_step%0d: got %h expected %h", i, obs, exp);
            end
            if (obs.x == 11'd11 && obs.y == 11'd6) begin
                found = 1'b1;
                checks++;
                if (fetch_x !== 11'd1 || fetch_y !== 11'd0) begin
                    errors++;
                    $display("[TB] FAIL frame_wrap_fetch: got (%0d,%0d) expected (1,0)",
                             fetch_x, fetch_y);
                end
            end
        end
        if (!found) begin
            checks++;
            errors++;
            $display("[TB] FAIL lookahead_timeout: position (11,6) not reached in 100 cycles");
        end
    endtask

    task automatic test_enable();
        vid_t obs, exp;
        bit   pattern [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int rep = 0; rep < 3; rep++) begin
            for (int i = 0; i < 4; i++) begin
                drive_cycle(pattern[i]);
                exp = sb.pop_front();
                obs = sample();
                checks++;
                if (obs !== exp) begin
                    errors++;
                    $display("[TB] FAIL enable_r%0d_s%0d: got %h expected %h", rep, i, obs, exp);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        vid_t obs, exp;
        bit   found = 1'b0;
        for (int i = 0; i < 2 * HT && !found; i++) begin
            drive_cycle(1'b1);
            exp = sb.pop_front();
            obs = sample();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("[TB] FAIL pre_reset_step%0d: got %h expected %h", i, obs, exp);
            end
            if (obs.x == 11'd9) found = 1'b1;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("[TB] FAIL reset_mid_timeout: out_x never reached 9");
        end
        #2;
        reset = 1'b1;
        #1;
        obs = sample();
        exp = reset_word();
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL async_reset_values: got %h expected %h", obs, exp);
        end
        @(negedge clk_pixel);
        enable = 1'b0;
        reset  = 1'b0;
        restart_model();
        drive_cycle(1'b1);
        exp = sb.pop_front();
        obs = sample();
        checks++;
        if (obs !== exp || obs.x !== 11'd0 || obs.hs !== 1'b1) begin
            errors++;
            $display("[TB] FAIL post_reset_first: got %h expected %h", obs, exp);
        end
    endtask

`ifdef VGA_TEST_PICTURE_EN
    task automatic test_colour();
        vid_t obs, exp;
        bit   seen_pix = 1'b0;
        bit   seen_blank = 1'b0;
        for (int i = 0; i < 100 && !(seen_pix && seen_blank); i++) begin
            drive_cycle(1'b1);
            exp = sb.pop_front();
            obs = sample();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("[TB] FAIL colour_step%0d: got %h expected %h", i, obs, exp);
            end
            if (obs.x == 11'd3 && obs.y == 11'd2) begin
                seen_pix = 1'b1;
                checks++;
                if ({vga_r, vga_g, vga_b} !== {2'd3, 2'd2, 2'd1}) begin
                    errors++;
                    $display("[TB] FAIL colour_3_2: got r%0d g%0d b%0d expected r3 g2 b1",
                             vga_r, vga_g, vga_b);
                end
            end
            if (seen_pix && obs.x == 11'd8) begin
                seen_blank = 1'b1;
                checks++;
                if ({vga_r, vga_g, vga_b} !== 6'd0) begin
                    errors++;
                    $display("[TB] FAIL colour_blank: got r%0d g%0d b%0d expected 0",
                             vga_r, vga_g, vga_b);
                end
            end
        end
        if (!(seen_pix && seen_blank)) begin
            checks++;
            errors++;
            $display("[TB] FAIL colour_timeout: colour positions not reached");
        end
    endtask
`endif

    initial begin
        test_reset();
        test_line();
        test_frame();
        test_lookahead();
        test_enable();
        test_reset_mid();
`ifdef VGA_TEST_PICTURE_EN
        test_colour();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
